// File: rtl/dyt_alu_issue.sv
// -----------------------------------------------------------------------------
// dyt_alu_issue
//
// Issue stage feeding dyt_alu. Takes one decoded-stage RV32I instruction and
// its register-file read data per handshake, works out which ALU operation and
// operands the instruction needs, and captures them in a one-entry ID/EX
// holding register. dyt_alu reads alu_op/alu_port_0/alu_port_1 straight out of
// that register in EX.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid         upstream instruction valid
//   in_ready         stage can accept this cycle (!out_valid || out_ready)
//   in_instr         RV32I instruction word
//   in_pc            instruction PC
//   rs1_data         register file read port 1
//   rs2_data         register file read port 2
//   flush            kill held and incoming instruction
//   out_valid        holding register occupied
//   out_ready        EX accepts the held entry
//   alu_op           ALU operation for dyt_alu
//   alu_port_0/1     ALU operands (SUB/SUBU compute port_1 - port_0)
//   out_rd           destination register field
//   out_wen          entry writes rd
//   out_branch       conditional branch, resolved in EX using out_funct3
//   out_funct3       funct3 passthrough
//   out_store_data   rs2_data for STORE, zero otherwise
//   out_pc           PC of the held entry, RESET_PC_TAG while empty
//   out_illegal      unsupported opcode/funct encoding
// -----------------------------------------------------------------------------

package dyt_alu_issue_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SUBU = 4'd2,
      ALU_SLL  = 4'd3,
      ALU_SLT  = 4'd4,
      ALU_SLTU = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_OR   = 4'd9,
      ALU_AND  = 4'd10
   } aluop_t;

endpackage

module dyt_alu_issue
   import dyt_alu_issue_pkg::*;
#(
   parameter int                WORD_W       = 32,
   parameter logic [WORD_W-1:0] RESET_PC_TAG = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [WORD_W-1:0] in_pc,
   input  logic [WORD_W-1:0] rs1_data,
   input  logic [WORD_W-1:0] rs2_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output aluop_t            alu_op,
   output logic [WORD_W-1:0] alu_port_0,
   output logic [WORD_W-1:0] alu_port_1,
   output logic [4:0]        out_rd,
   output logic              out_wen,
   output logic              out_branch,
   output logic [2:0]        out_funct3,
   output logic [WORD_W-1:0] out_store_data,
   output logic [WORD_W-1:0] out_pc,
   output logic              out_illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Instruction fields
   logic [6:0]        w_opcode;
   logic [2:0]        w_funct3;
   logic [6:0]        w_funct7;
   logic [4:0]        w_rd;
   logic              w_f7Zero;
   logic              w_f7Alt;

   // Immediates, all sign-extended (or zero-extended for shift amounts)
   logic [WORD_W-1:0] w_immI;
   logic [WORD_W-1:0] w_immS;
   logic [WORD_W-1:0] w_immU;
   logic [WORD_W-1:0] w_shamtImm;
   logic [WORD_W-1:0] w_shamtReg;

   // Decoded entry, ready to be captured
   aluop_t            w_op;
   logic [WORD_W-1:0] w_p0;
   logic [WORD_W-1:0] w_p1;
   logic              w_wen;
   logic              w_branch;
   logic              w_ill;
   logic [WORD_W-1:0] w_storeData;
   logic              w_load;

   // Holding register
   logic              r_valid;
   aluop_t            r_op;
   logic [WORD_W-1:0] r_p0;
   logic [WORD_W-1:0] r_p1;
   logic [4:0]        r_rd;
   logic              r_wen;
   logic              r_branch;
   logic [2:0]        r_funct3;
   logic [WORD_W-1:0] r_storeData;
   logic [WORD_W-1:0] r_pc;
   logic              r_ill;

   assign w_opcode = in_instr[6:0];
   assign w_rd     = in_instr[11:7];
   assign w_funct3 = in_instr[14:12];
   assign w_funct7 = in_instr[31:25];
   assign w_f7Zero = (w_funct7 == 7'b0000000);
   assign w_f7Alt  = (w_funct7 == 7'b0100000);

   // The size casts of signed expressions sign-extend to WORD_W (or truncate
   // if WORD_W is narrower than the architectural 32 bits).
   assign w_immI     = WORD_W'($signed(in_instr[31:20]));
   assign w_immS     = WORD_W'($signed({in_instr[31:25], in_instr[11:7]}));
   assign w_immU     = WORD_W'($signed({in_instr[31:12], 12'b0}));
   assign w_shamtImm = WORD_W'(in_instr[24:20]);
   assign w_shamtReg = WORD_W'(rs2_data[4:0]);

   // Full throughput: a new entry can enter in the same cycle the held one
   // leaves. in_ready deliberately ignores flush.
   assign in_ready = !r_valid || out_ready;
   assign w_load   = in_valid && in_ready && !flush;

   // Decode. dyt_alu subtracts port_0 from port_1, so every subtracting case
   // (SUB and BEQ/BNE) swaps rs1/rs2 onto the ports. Illegal encodings are
   // collapsed to a harmless ADD of zeros at the end so EX never acts on them.
   always_comb begin
      w_op        = ALU_ADD;
      w_p0        = '0;
      w_p1        = '0;
      w_wen       = 1'b0;
      w_branch    = 1'b0;
      w_ill       = 1'b0;
      w_storeData = '0;

      case (w_opcode)
         OPC_OP: begin
            if (!(w_f7Zero || (w_f7Alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101)))) begin
               w_ill = 1'b1;
            end else begin
               w_p0  = rs1_data;
               w_p1  = rs2_data;
               w_wen = 1'b1;
               case (w_funct3)
                  3'b000: begin
                     if (w_f7Alt) begin
                        w_op = ALU_SUB;
                        w_p0 = rs2_data;
                        w_p1 = rs1_data;
                     end else begin
                        w_op = ALU_ADD;
                     end
                  end
                  3'b001: begin
                     w_op = ALU_SLL;
                     w_p1 = w_shamtReg;
                  end
                  3'b010:  w_op = ALU_SLT;
                  3'b011:  w_op = ALU_SLTU;
                  3'b100:  w_op = ALU_XOR;
                  3'b101: begin
                     w_op = w_f7Alt ? ALU_SRA : ALU_SRL;
                     w_p1 = w_shamtReg;
                  end
                  3'b110:  w_op = ALU_OR;
                  default: w_op = ALU_AND;
               endcase
            end
         end

         OPC_OP_IMM: begin
            w_p0  = rs1_data;
            w_p1  = w_immI;
            w_wen = 1'b1;
            case (w_funct3)
               3'b000: w_op = ALU_ADD;
               3'b010: w_op = ALU_SLT;
               3'b011: w_op = ALU_SLTU;
               3'b100: w_op = ALU_XOR;
               3'b110: w_op = ALU_OR;
               3'b111: w_op = ALU_AND;
               3'b001: begin
                  w_op  = ALU_SLL;
                  w_p1  = w_shamtImm;
                  w_ill = !w_f7Zero;
               end
               default: begin
                  w_op  = w_f7Alt ? ALU_SRA : ALU_SRL;
                  w_p1  = w_shamtImm;
                  w_ill = !(w_f7Zero || w_f7Alt);
               end
            endcase
         end

         OPC_LUI: begin
            w_p1  = w_immU;
            w_wen = 1'b1;
         end

         OPC_AUIPC: begin
            w_p0  = in_pc;
            w_p1  = w_immU;
            w_wen = 1'b1;
         end

         OPC_LOAD: begin
            w_p0  = rs1_data;
            w_p1  = w_immI;
            w_wen = 1'b1;
         end

         OPC_STORE: begin
            w_p0        = rs1_data;
            w_p1        = w_immS;
            w_storeData = rs2_data;
         end

         OPC_BRANCH: begin
            w_branch = 1'b1;
            case (w_funct3)
               3'b000, 3'b001: begin
                  w_op = ALU_SUB;
                  w_p0 = rs2_data;
                  w_p1 = rs1_data;
               end
               3'b100, 3'b101: begin
                  w_op = ALU_SLT;
                  w_p0 = rs1_data;
                  w_p1 = rs2_data;
               end
               3'b110, 3'b111: begin
                  w_op = ALU_SLTU;
                  w_p0 = rs1_data;
                  w_p1 = rs2_data;
               end
               default: w_ill = 1'b1;
            endcase
         end

         default: w_ill = 1'b1;
      endcase

      if (w_ill) begin
         w_op        = ALU_ADD;
         w_p0        = '0;
         w_p1        = '0;
         w_wen       = 1'b0;
         w_branch    = 1'b0;
         w_storeData = '0;
      end

      if (w_rd == 5'd0) begin
         w_wen = 1'b0;
      end
   end

   // ID/EX holding register. flush wins over both a new load and a consume;
   // otherwise a load replaces the entry and a consume without a load empties
   // it. The payload only changes on a load, so it is stable while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_op        <= ALU_ADD;
         r_p0        <= '0;
         r_p1        <= '0;
         r_rd        <= '0;
         r_wen       <= 1'b0;
         r_branch    <= 1'b0;
         r_funct3    <= '0;
         r_storeData <= '0;
         r_pc        <= '0;
         r_ill       <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid     <= 1'b1;
         r_op        <= w_op;
         r_p0        <= w_p0;
         r_p1        <= w_p1;
         r_rd        <= w_rd;
         r_wen       <= w_wen;
         r_branch    <= w_branch;
         r_funct3    <= w_funct3;
         r_storeData <= w_storeData;
         r_pc        <= in_pc;
         r_ill       <= w_ill;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid      = r_valid;
   assign alu_op         = r_op;
   assign alu_port_0     = r_p0;
   assign alu_port_1     = r_p1;
   assign out_rd         = r_rd;
   assign out_wen        = r_wen;
   assign out_branch     = r_branch;
   assign out_funct3     = r_funct3;
   assign out_store_data = r_storeData;
   assign out_illegal    = r_ill;

   // An empty entry advertises the reset tag rather than a stale PC.
   assign out_pc = r_valid ? r_pc : RESET_PC_TAG;

endmodule

// File: tb/tb_dyt_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_dyt_alu_issue
//
// Directed bench for dyt_alu_issue. The driver pushes the hand-computed
// expected entry into a scoreboard queue when the DUT accepts an instruction;
// the monitor pops and compares whenever EX consumes the held entry.
// -----------------------------------------------------------------------------

module tb_dyt_alu_issue;
   import dyt_alu_issue_pkg::*;

   localparam logic [31:0] PC_TAG = 32'h0000_0080;

   typedef struct {
      aluop_t      op;
      logic [31:0] p0;
      logic [31:0] p1;
      logic [4:0]  rd;
      logic        wen;
      logic        br;
      logic [2:0]  f3;
      logic [31:0] sd;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        inValid;
   logic        inReady;
   logic [31:0] inInstr;
   logic [31:0] inPc;
   logic [31:0] rs1Data;
   logic [31:0] rs2Data;
   logic        flush;
   logic        outValid;
   logic        outReady;
   aluop_t      aluOp;
   logic [31:0] aluPort0;
   logic [31:0] aluPort1;
   logic [4:0]  outRd;
   logic        outWen;
   logic        outBranch;
   logic [2:0]  outFunct3;
   logic [31:0] outStoreData;
   logic [31:0] outPc;
   logic        outIllegal;

   int   checks = 0;
   int   errors = 0;
   exp_t sbQ[$];

   dyt_alu_issue #(
      .WORD_W       (32),
      .RESET_PC_TAG (PC_TAG)
   ) dut (
      .clk            (clock),
      .rst            (reset),
      .in_valid       (inValid),
      .in_ready       (inReady),
      .in_instr       (inInstr),
      .in_pc          (inPc),
      .rs1_data       (rs1Data),
      .rs2_data       (rs2Data),
      .flush          (flush),
      .out_valid      (outValid),
      .out_ready      (outReady),
      .alu_op         (aluOp),
      .alu_port_0     (aluPort0),
      .alu_port_1     (aluPort1),
      .out_rd         (outRd),
      .out_wen        (outWen),
      .out_branch     (outBranch),
      .out_funct3     (outFunct3),
      .out_store_data (outStoreData),
      .out_pc         (outPc),
      .out_illegal    (outIllegal)
   );

   // Free-running clock, period 10
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Safety net in case a handshake never completes
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic exp_t mk(aluop_t op, logic [31:0] p0, logic [31:0] p1,
                               logic [4:0] rd, logic wen, logic br, logic [2:0] f3,
                               logic [31:0] sd, logic [31:0] pc, logic ill);
      exp_t e;
      e.op  = op;
      e.p0  = p0;
      e.p1  = p1;
      e.rd  = rd;
      e.wen = wen;
      e.br  = br;
      e.f3  = f3;
      e.sd  = sd;
      e.pc  = pc;
      e.ill = ill;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one instruction (called #1 after a rising edge), wait for the DUT
   // to take it, record what it should produce, then drop in_valid.
   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] a, input logic [31:0] b, input exp_t e);
      bit taken = 0;
      inInstr = instr;
      inPc    = pc;
      rs1Data = a;
      rs2Data = b;
      inValid = 1'b1;
      for (int i = 0; i < 50 && !taken; i++) begin
         @(negedge clock);
         if (inReady) begin
            sbQ.push_back(e);
            taken = 1;
         end
         @(posedge clock);
         #1;
      end
      if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
      inValid = 1'b0;
   endtask

   // Monitor: a transfer to EX happens at the next rising edge whenever the
   // entry is valid, EX is ready and no flush is pending.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && outValid && outReady && !flush) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpected_entry", {27'd0, outRd}, 32'hFFFF_FFFF);
            end else begin
               e = sbQ.pop_front();
               checkOutput("alu_op",     32'(aluOp),        32'(e.op));
               checkOutput("port_0",     aluPort0,          e.p0);
               checkOutput("port_1",     aluPort1,          e.p1);
               checkOutput("out_rd",     32'(outRd),        32'(e.rd));
               checkOutput("out_wen",    32'(outWen),       32'(e.wen));
               checkOutput("out_branch", 32'(outBranch),    32'(e.br));
               checkOutput("out_funct3", 32'(outFunct3),    32'(e.f3));
               checkOutput("store_data", outStoreData,      e.sd);
               checkOutput("out_pc",     outPc,             e.pc);
               checkOutput("illegal",    32'(outIllegal),   32'(e.ill));
            end
         end
      end
   end

   initial begin
      reset    = 1'b1;
      inValid  = 1'b0;
      inInstr  = '0;
      inPc     = '0;
      rs1Data  = '0;
      rs2Data  = '0;
      flush    = 1'b0;
      outReady = 1'b1;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_alu_op",    32'(aluOp),    32'(ALU_ADD));
      checkOutput("rst_port_0",    aluPort0,      32'd0);
      checkOutput("rst_out_pc",    outPc,         PC_TAG);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("post_rst_in_ready", 32'(inReady), 32'd1);
      @(posedge clock);
      #1;

      // Directed vectors with out_ready held high
      applyStimulus(32'h002081B3, 32'h10, 32'd5, 32'd7,
                    mk(ALU_ADD, 32'd5, 32'd7, 5'd3, 1, 0, 3'd0, 0, 32'h10, 0));
      applyStimulus(32'h402081B3, 32'h14, 32'd5, 32'd7,
                    mk(ALU_SUB, 32'd7, 32'd5, 5'd3, 1, 0, 3'd0, 0, 32'h14, 0));
      applyStimulus(32'h40335293, 32'h18, 32'hFFFF_FF00, 32'd0,
                    mk(ALU_SRA, 32'hFFFF_FF00, 32'd3, 5'd5, 1, 0, 3'd5, 0, 32'h18, 0));
      applyStimulus(32'h123450B7, 32'h1C, 32'hAAAA_AAAA, 32'd0,
                    mk(ALU_ADD, 32'd0, 32'h1234_5000, 5'd1, 1, 0, 3'd5, 0, 32'h1C, 0));
      applyStimulus(32'h12345097, 32'h100, 32'hAAAA_AAAA, 32'd0,
                    mk(ALU_ADD, 32'h100, 32'h1234_5000, 5'd1, 1, 0, 3'd5, 0, 32'h100, 0));
      applyStimulus(32'h00000000, 32'h104, 32'd9, 32'd9,
                    mk(ALU_ADD, 32'd0, 32'd0, 5'd0, 0, 0, 3'd0, 0, 32'h104, 1));
      applyStimulus(32'h00208033, 32'h108, 32'd5, 32'd7,
                    mk(ALU_ADD, 32'd5, 32'd7, 5'd0, 0, 0, 3'd0, 0, 32'h108, 0));
      applyStimulus(32'hFFF10093, 32'h10C, 32'd20, 32'd0,
                    mk(ALU_ADD, 32'd20, 32'hFFFF_FFFF, 5'd1, 1, 0, 3'd0, 0, 32'h10C, 0));
      applyStimulus(32'h0020A423, 32'h110, 32'h1000, 32'hDEAD_BEEF,
                    mk(ALU_ADD, 32'h1000, 32'd8, 5'd8, 0, 0, 3'd2, 32'hDEAD_BEEF, 32'h110, 0));
      applyStimulus(32'h00208463, 32'h114, 32'd11, 32'd22,
                    mk(ALU_SUB, 32'd22, 32'd11, 5'd8, 0, 1, 3'd0, 0, 32'h114, 0));
      applyStimulus(32'h0020E463, 32'h118, 32'd11, 32'd22,
                    mk(ALU_SLTU, 32'd11, 32'd22, 5'd8, 0, 1, 3'd6, 0, 32'h118, 0));
      applyStimulus(32'h0020A463, 32'h11C, 32'd11, 32'd22,
                    mk(ALU_ADD, 32'd0, 32'd0, 5'd8, 0, 0, 3'd2, 0, 32'h11C, 1));
      applyStimulus(32'h002091B3, 32'h120, 32'd1, 32'h25,
                    mk(ALU_SLL, 32'd1, 32'd5, 5'd3, 1, 0, 3'd1, 0, 32'h120, 0));
      applyStimulus(32'h022081B3, 32'h124, 32'd1, 32'd2,
                    mk(ALU_ADD, 32'd0, 32'd0, 5'd3, 0, 0, 3'd0, 0, 32'h124, 1));
      repeat (2) @(posedge clock);
      #1;
      checkOutput("empty_out_pc", outPc, PC_TAG);

      // Backpressure: first entry is held for 4 cycles while two more wait
      outReady = 1'b0;
      inInstr  = 32'h002081B3;
      inPc     = 32'h200;
      rs1Data  = 32'd100;
      rs2Data  = 32'd200;
      inValid  = 1'b1;
      @(negedge clock);
      checkOutput("bp_first_ready", 32'(inReady), 32'd1);
      sbQ.push_back(mk(ALU_ADD, 32'd100, 32'd200, 5'd3, 1, 0, 3'd0, 0, 32'h200, 0));
      @(posedge clock);
      #1;
      inInstr = 32'h402081B3;
      inPc    = 32'h204;
      rs1Data = 32'd1;
      rs2Data = 32'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkOutput("bp_in_ready", 32'(inReady),  32'd0);
         checkOutput("bp_valid",    32'(outValid), 32'd1);
         checkOutput("bp_port_0",   aluPort0,      32'd100);
         checkOutput("bp_pc",       outPc,         32'h200);
         @(posedge clock);
         #1;
      end
      outReady = 1'b1;
      applyStimulus(32'h402081B3, 32'h204, 32'd1, 32'd3,
                    mk(ALU_SUB, 32'd3, 32'd1, 5'd3, 1, 0, 3'd0, 0, 32'h204, 0));
      applyStimulus(32'h0020F1B3, 32'h208, 32'hF0F0, 32'hFF00,
                    mk(ALU_AND, 32'hF0F0, 32'hFF00, 5'd3, 1, 0, 3'd7, 0, 32'h208, 0));
      repeat (2) @(posedge clock);
      #1;

      // Flush with a held entry and a new instruction in the same cycle
      outReady = 1'b0;
      inInstr  = 32'h002081B3;
      inPc     = 32'h300;
      rs1Data  = 32'd1;
      rs2Data  = 32'd1;
      inValid  = 1'b1;
      @(posedge clock);
      #1;
      outReady = 1'b1;
      flush    = 1'b1;
      inInstr  = 32'h402081B3;
      inPc     = 32'h304;
      @(negedge clock);
      checkOutput("flush_in_ready", 32'(inReady), 32'd1);
      @(posedge clock);
      #1;
      flush   = 1'b0;
      inValid = 1'b0;
      @(negedge clock);
      checkOutput("flush_out_valid", 32'(outValid), 32'd0);
      @(posedge clock);
      #1;

      // Asynchronous reset while an entry is stalled
      outReady = 1'b0;
      inInstr  = 32'h002081B3;
      inPc     = 32'h400;
      rs1Data  = 32'd55;
      rs2Data  = 32'd66;
      inValid  = 1'b1;
      @(posedge clock);
      #1;
      inValid = 1'b0;
      checkOutput("stall_held", 32'(outValid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst_valid",  32'(outValid), 32'd0);
      checkOutput("arst_port_0", aluPort0,      32'd0);
      checkOutput("arst_port_1", aluPort1,      32'd0);
      checkOutput("arst_wen",    32'(outWen),   32'd0);
      checkOutput("arst_pc",     outPc,         PC_TAG);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("arst_in_ready", 32'(inReady), 32'd1);
      @(posedge clock);
      #1;
      outReady = 1'b1;

      // One more entry after reset to show the stage still works
      applyStimulus(32'h0020C1B3, 32'h500, 32'h0F0F, 32'h00FF,
                    mk(ALU_XOR, 32'h0F0F, 32'h00FF, 5'd3, 1, 0, 3'd4, 0, 32'h500, 0));
      repeat (3) @(posedge clock);
      #1;
      checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dyt_alu_issue.md
Name: dyt_alu_issue

Overview:
- Issue stage on the driving side of dyt_alu_if: accepts one decoded-stage RV32I instruction plus register-file read data per handshake.
- Selects the ALU operation and operands, and registers them into a one-entry ID/EX holding register. The dyt_alu consumes that register's outputs combinationally in EX.
- Handles operand ordering, immediate generation and shift-amount masking so that dyt_alu results match RV32I semantics.

Parameters:
WORD_W, 32, datapath width; matches common_types WORD_W
RESET_PC_TAG, 0, value driven on out_pc while the entry is empty

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  issue stage can accept this cycle
in_instr  in  32  RV32I instruction word
in_pc  in  WORD_W  instruction PC
rs1_data  in  WORD_W  register file read port 1
rs2_data  in  WORD_W  register file read port 2
flush  in  1  kill held and incoming instruction
out_valid  out  1  holding register occupied
out_ready  in  1  EX accepts held entry
alu_op  out  aluop_t  to dyt_alu_if.alu_op
alu_port_0  out  WORD_W  to dyt_alu_if.alu_port_0
alu_port_1  out  WORD_W  to dyt_alu_if.alu_port_1
out_rd  out  5  destination register
out_wen  out  1  writes rd (0 for STORE/BRANCH/illegal/rd==x0)
out_branch  out  1  conditional branch; EX resolves with out_funct3
out_funct3  out  3  funct3 passthrough
out_store_data  out  WORD_W  rs2_data for STORE
out_pc  out  WORD_W  PC of held entry
out_illegal  out  1  unsupported opcode/funct encoding

Behaviour:
- Reset (async on rst high):
  - All outputs and registers go to 0; out_pc goes to RESET_PC_TAG; alu_op goes to ALU_ADD.
  - in_ready is 1 on the first cycle after rst falls.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, full throughput).
  - Load on in_valid && in_ready && !flush. Latency is 1 cycle from accept to out_valid.
  - Held entry and all outputs are stable while out_valid && !out_ready.
- flush:
  - The next edge clears out_valid.
  - An input presented in the same cycle is dropped; in_ready still reads 1.
  - flush has priority over load and over out_ready.
- Operand mapping (dyt_alu computes SUB/SUBU as port_1 - port_0):
  - OP ADD/XOR/OR/AND/SLT/SLTU: port_0=rs1, port_1=rs2.
  - OP SUB: alu_op=ALU_SUB, port_0=rs2, port_1=rs1.
  - OP SLL/SRL/SRA: port_0=rs1, port_1=zero-extended rs2[4:0].
  - OP-IMM: port_1 = sign-extended I-imm.
  - OP-IMM SLLI/SRLI/SRAI: port_1 = shamt[4:0]; SRAI requires funct7=0100000, else illegal.
  - LUI: ALU_ADD, port_0=0, port_1={imm[31:12],12'b0}.
  - AUIPC: ALU_ADD, port_0=in_pc, port_1=U-imm.
  - LOAD: ALU_ADD, port_0=rs1, port_1=I-imm, wen=1.
  - STORE: ALU_ADD, port_0=rs1, port_1=S-imm, wen=0, store_data=rs2.
  - BRANCH BEQ/BNE: ALU_SUB, port_0=rs2, port_1=rs1; EX tests alu_zero.
  - BRANCH BLT/BGE: ALU_SLT, port_0=rs1, port_1=rs2.
  - BRANCH BLTU/BGEU: ALU_SLTU, port_0=rs1, port_1=rs2.
  - All immediates are sign-extended to WORD_W; results are truncated mod 2^WORD_W.
- Illegal: any other opcode, funct7 not in {0000000, 0100000 for SUB/SRA}, or BRANCH funct3 010/011.
  - Sets out_illegal=1, out_wen=0, out_branch=0, alu_op=ALU_ADD, ports=0.
  - The entry still handshakes normally.
- rd==x0 forces out_wen=0.
- Reset mid-stall discards the held entry with no output glitch beyond async clear.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_op=ALU_ADD, port_0=5, port_1=7, out_rd=3, out_wen=1.
- SUB (0x402081B3), rs1=5, rs2=7 -> alu_op=ALU_SUB, port_0=7, port_1=5 (so the ALU yields 0xFFFFFFFE); SRAI x5,x6,3 (0x40335293), rs1=0xFFFFFF00 -> ALU_SRA, port_1=3, out_rd=5.
- LUI x1,0x12345 (0x123450B7) -> ALU_ADD, port_0=0, port_1=0x12345000; AUIPC with in_pc=0x100 and same imm -> port_0=0x100.
- Backpressure: three back-to-back valid instructions, out_ready=0 for 4 cycles -> in_ready=0, first entry held unchanged, none lost or duplicated once out_ready=1.
- flush asserted with a held entry and a new in_valid in the same cycle -> out_valid=0 next cycle; the dropped instruction never appears.
- in_instr=0x00000000 -> out_illegal=1, out_wen=0; ADD with rd=x0 -> out_wen=0; rst pulsed while stalled -> all outputs 0 asynchronously.
